// File: rtl/fir_frame_driver.sv
// fir_frame_driver: buffers samples in a FIFO and sequences full frames through a 3-tap FIR core
// Ports: in_valid/in_ready/in_data sample input; fir_clr/fir_start/fir_stop/fir_x drive the FIR,
// fir_done/fir_y come back from it; out_valid/out_ready/out_data return the result;
// busy = not idle, err = sticky WAIT timeout.
module fir_frame_driver #(
    parameter int DATAWIDTH = 16,
    parameter int YWIDTH    = 34,
    parameter int FRAME_LEN = 4,
    parameter int DEPTH     = 8,
    parameter int Y_LAT     = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 fir_clr,
    output logic                 fir_start,
    output logic                 fir_stop,
    output logic [DATAWIDTH-1:0] fir_x,
    input  logic                 fir_done,
    input  logic [YWIDTH-1:0]    fir_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [YWIDTH-1:0]    out_data,
    output logic                 busy,
    output logic                 err
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(FRAME_LEN + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(Y_LAT + 2);

    typedef enum logic [2:0] {IDLE, CLEAR, ARM, STREAM, WAIT, HOLD} state_t;

    state_t               state, state_nxt;
    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [SW-1:0]        samp_cnt, samp_nxt;
    logic [WW-1:0]        wait_cnt;
    logic [LW-1:0]        lat_cnt;
    logic                 done_seen, push, pop, cap, abort, hit;

    assign in_ready = count < CW'(DEPTH);
    assign push     = in_valid & in_ready;
    assign busy     = state != IDLE;
    assign samp_nxt = state == ARM ? SW'(1) : samp_cnt + SW'(1);
    // lat_cnt counts cycles since the first fir_done; Y_LAT=0 captures in the done cycle itself
    assign hit      = done_seen ? lat_cnt == LW'(Y_LAT) : fir_done && Y_LAT == 0;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        cap       = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE:   state_nxt = count >= CW'(FRAME_LEN) ? CLEAR : IDLE;
            CLEAR:  state_nxt = ARM;
            ARM: begin
                pop       = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                pop       = samp_cnt != SW'(FRAME_LEN);
                state_nxt = pop ? STREAM : WAIT;
            end
            WAIT: begin
                cap       = hit;
                abort     = !hit && !done_seen && !fir_done && wait_cnt == WW'(TIMEOUT - 1);
                state_nxt = cap ? HOLD : abort ? IDLE : WAIT;
            end
            HOLD:   state_nxt = out_ready ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // every FIR-facing output is registered from the next-state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            samp_cnt  <= '0;
            wait_cnt  <= '0;
            lat_cnt   <= '0;
            done_seen <= 1'b0;
            fir_clr   <= 1'b0;
            fir_start <= 1'b0;
            fir_stop  <= 1'b0;
            fir_x     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            count     <= count + CW'(push) - CW'(pop);
            samp_cnt  <= pop ? samp_nxt : samp_cnt;
            wait_cnt  <= state == WAIT ? wait_cnt + WW'(1) : '0;
            done_seen <= state == WAIT && (done_seen || fir_done);
            lat_cnt   <= state == WAIT && (done_seen || fir_done) ? lat_cnt + LW'(1) : '0;
            fir_clr   <= state_nxt == CLEAR;
            fir_start <= state_nxt == ARM;
            fir_x     <= pop ? mem[rd_ptr] : '0;
            fir_stop  <= pop && samp_nxt == SW'(FRAME_LEN);
            out_valid <= cap | (out_valid & !(state == HOLD && out_ready));
            out_data  <= cap ? fir_y : out_data;
            err       <= err | abort;
        end
    end
endmodule
